// File: rtl/tc_parade.sv
// tc_parade: two-street traffic-light controller with a latched parade mode.
// Street A and street B each get a one-hot {red, yellow, green} lamp. A mode
// bit, set by P and cleared by R, holds street B green while a parade runs.
module tc_parade #(
    parameter int unsigned YELLOW_CYCLES = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       P,
    input  logic       R,
    input  logic       T_A,
    input  logic       T_B,
    output logic [2:0] L_A,
    output logic [2:0] L_B
);

    typedef enum logic [1:0] {
        SA_GREEN  = 2'd0,
        SA_YELLOW = 2'd1,
        SB_GREEN  = 2'd2,
        SB_YELLOW = 2'd3
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    // Counter value on the final cycle of a yellow phase; the counter starts
    // at zero on yellow entry, so this is the phase length minus one.
    localparam logic [7:0] YEL_LAST = 8'(YELLOW_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;

    // State register for both FSMs and the yellow counter; reset wins over all inputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= SA_GREEN;
            cnt_q   <= 8'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Mode FSM next state: release beats request when both are asserted.
    always_comb begin
        mode_d = mode_q;
        if (R) begin
            mode_d = 1'b0;
        end else if (P) begin
            mode_d = 1'b1;
        end
    end

    // Lights FSM next state; uses the registered mode so P/R act one cycle late.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SA_GREEN: begin
                if (!T_A) begin
                    state_d = SA_YELLOW;
                    cnt_d   = 8'd0;
                end
            end
            SA_YELLOW: begin
                // An in-progress yellow always completes, even in parade mode.
                if (cnt_q == YEL_LAST) begin
                    state_d = SB_GREEN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SB_GREEN: begin
                // Parade mode pins street B green regardless of B traffic.
                if (!T_B && !mode_q) begin
                    state_d = SB_YELLOW;
                    cnt_d   = 8'd0;
                end
            end
            SB_YELLOW: begin
                if (cnt_q == YEL_LAST) begin
                    state_d = SA_GREEN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = SA_GREEN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Moore lamp decode; every state keeps at least one head red.
    always_comb begin
        L_A = LAMP_RED;
        L_B = LAMP_RED;
        case (state_q)
            SA_GREEN:  begin L_A = LAMP_GREEN;  L_B = LAMP_RED;    end
            SA_YELLOW: begin L_A = LAMP_YELLOW; L_B = LAMP_RED;    end
            SB_GREEN:  begin L_A = LAMP_RED;    L_B = LAMP_GREEN;  end
            SB_YELLOW: begin L_A = LAMP_RED;    L_B = LAMP_YELLOW; end
            default:   begin L_A = LAMP_RED;    L_B = LAMP_RED;    end
        endcase
    end

endmodule

// File: tb/tb_tc_parade.sv
// Bench for tc_parade: a table of vectors with hand-computed lamp values,
// then hand-written multi-cycle sequences checked against a behavioural model.
module tb_tc_parade;

    localparam int YC = 5;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] RD = 3'b100;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       P = 1'b0;
    logic       R = 1'b0;
    logic       T_A = 1'b1;
    logic       T_B = 1'b0;
    logic [2:0] L_A;
    logic [2:0] L_B;

    tc_parade #(.YELLOW_CYCLES(YC)) dut (
        .CLK(CLK), .RESET(RESET), .P(P), .R(R), .T_A(T_A), .T_B(T_B),
        .L_A(L_A), .L_B(L_B)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst, p, r, ta, tb;
        logic [2:0] la, lb;
    } vec_t;

    vec_t        tbl[$];
    logic [5:0]  sb_q[$];
    int          errors = 0;
    int          checks = 0;

    // Behavioural model: phase 0..3 = A green, A yellow, B green, B yellow;
    // rem counts yellow cycles still to show, including the current one.
    int   m_ph = 0;
    int   m_rem = 0;
    logic m_mode = 1'b0;

    function automatic logic [5:0] lamps(int ph);
        case (ph)
            0: return {G, RD};
            1: return {Y, RD};
            2: return {RD, G};
            default: return {RD, Y};
        endcase
    endfunction

    task automatic model_edge(input logic rst, p, r, ta, tb);
        if (rst) begin
            m_ph = 0; m_rem = 0; m_mode = 1'b0;
        end else begin
            if (m_ph == 0) begin
                if (!ta) begin m_ph = 1; m_rem = YC; end
            end else if (m_ph == 2) begin
                if (!tb && !m_mode) begin m_ph = 3; m_rem = YC; end
            end else begin
                if (m_rem == 1) m_ph = (m_ph == 1) ? 2 : 0;
                else m_rem = m_rem - 1;
            end
            if (r) m_mode = 1'b0;
            else if (p) m_mode = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got L_A=%b L_B=%b, expected L_A=%b L_B=%b",
                     name, act[5:3], act[2:0], exp[5:3], exp[2:0]);
        end
    endtask

    // Drive one cycle: push expected lamps, take the edge, pop and compare.
    task automatic step(input string name, input logic rst, p, r, ta, tb,
                        input bit use_tbl, input logic [5:0] texp);
        logic [5:0] exp;
        RESET = rst; P = p; R = r; T_A = ta; T_B = tb;
        model_edge(rst, p, r, ta, tb);
        sb_q.push_back(use_tbl ? texp : lamps(m_ph));
        @(posedge CLK);
        #1;
        exp = sb_q.pop_front();
        check(name, {L_A, L_B}, exp);
        checks++;
        if (L_A != RD && L_B != RD) begin
            errors++;
            $display("FAIL %s_red: both heads non-red L_A=%b L_B=%b, required one red",
                     name, L_A, L_B);
        end
    endtask

    task automatic mstep(input string name, input logic rst, p, r, ta, tb);
        step(name, rst, p, r, ta, tb, 1'b0, 6'd0);
    endtask

    task automatic add(input int n, input logic rst, p, r, ta, tb, input logic [2:0] la, lb);
        vec_t v;
        v.rst = rst; v.p = p; v.r = r; v.ta = ta; v.tb = tb; v.la = la; v.lb = lb;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        // Reset, then A holds green while A traffic is present.
        add(1,  1, 0, 0, 1, 0, G,  RD);
        add(10, 0, 0, 0, 1, 0, G,  RD);
        // Full normal cycle: 5 yellow, 1 B green, 5 B yellow, back to A.
        add(YC, 0, 0, 0, 0, 0, Y,  RD);
        add(1,  0, 0, 0, 0, 0, RD, G);
        add(YC, 0, 0, 0, 1, 0, RD, Y);
        add(3,  0, 0, 0, 1, 0, G,  RD);
        // B traffic holds B green; dropping T_B yields on the next edge.
        add(YC, 0, 0, 0, 0, 1, Y,  RD);
        add(1,  0, 0, 0, 0, 1, RD, G);
        add(3,  0, 0, 0, 1, 1, RD, G);
        add(YC, 0, 0, 0, 1, 0, RD, Y);
        add(1,  0, 0, 0, 1, 0, G,  RD);
        // Reset in the middle of B yellow.
        add(YC, 0, 0, 0, 0, 0, Y,  RD);
        add(1,  0, 0, 0, 0, 0, RD, G);
        add(2,  0, 0, 0, 1, 0, RD, Y);
        add(1,  1, 0, 0, 1, 0, G,  RD);
        add(2,  0, 0, 0, 1, 0, G,  RD);

        @(posedge CLK);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].p, tbl[i].r,
                 tbl[i].ta, tbl[i].tb, 1'b1, {tbl[i].la, tbl[i].lb});
        end

        // Parade: P pulse, then sequence runs into B green and holds.
        mstep("par_p", 0, 1, 0, 1, 0);
        for (int i = 0; i < 60; i++) mstep("par_hold", 0, 0, 0, 0, 0);
        check("par_held_green", {L_A, L_B}, {RD, G});
        mstep("par_r", 0, 0, 1, 0, 0);
        mstep("par_rel", 0, 0, 0, 0, 0);
        check("par_release_yellow", {L_A, L_B}, {RD, Y});
        for (int i = 0; i < YC; i++) mstep("par_tail", 0, 0, 0, 1, 0);
        check("par_back_a", {L_A, L_B}, {G, RD});

        // P and R together: release wins, lights cycle with period 12.
        for (int i = 0; i < 24; i++) mstep("pr_both", 0, 1, 1, 0, 0);
        check("pr_period_end", {L_A, L_B}, {G, RD});
        for (int i = 0; i < 12; i++) mstep("pr_tail", 0, 0, 0, 1, 0);

        // P during A yellow: yellow completes into B green, then holds.
        mstep("ay_enter", 0, 0, 0, 0, 0);
        mstep("ay_p", 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) mstep("ay_hold", 0, 0, 0, 0, 0);
        check("ay_held_green", {L_A, L_B}, {RD, G});

        // Reset clears parade mode: normal cycling resumes.
        mstep("rst_mode", 1, 0, 0, 0, 0);
        check("rst_lamps", {L_A, L_B}, {G, RD});
        for (int i = 0; i < 8; i++) mstep("rst_cycle", 0, 0, 0, 0, 0);
        check("rst_mode_clear", {L_A, L_B}, {RD, Y});
        for (int i = 0; i < 6; i++) mstep("rst_tail", 0, 0, 0, 1, 0);

        // Parade does not release A green while A traffic is present.
        mstep("sag_p", 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) mstep("sag_hold", 0, 0, 0, 1, 0);
        check("sag_still_green", {L_A, L_B}, {G, RD});
        mstep("sag_r", 0, 0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
